// File: rtl/empty_flag_calc.sv
// Read-side pointer and flag logic for a dual-clock FIFO: binary read pointer,
// registered Gray pointer for the write domain, and empty/level/underflow status.
module empty_flag_calc #(
  parameter int ADDR      = 4,
  parameter int AE_THRESH = 2
) (
  input  logic            rd_clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic            clr_err,
  input  logic [ADDR:0]   sync_wr_ptr,
  output logic [ADDR-1:0] rd_add,
  output logic [ADDR:0]   gr_rd_ptr,
  output logic            empty_flag,
  output logic            almost_empty_flag,
  output logic [ADDR:0]   rd_level,
  output logic            underflow,
  output logic            underflow_sticky
);

  localparam logic [ADDR:0] AeThresh = AE_THRESH[ADDR:0];

  logic [ADDR:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0] gray_q, gray_d;
  logic [ADDR:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          uf_q, uf_d;
  logic          sticky_q, sticky_d;
  logic [ADDR:0] bin_wr_ptr;
  logic          acc;

  // Acceptance looks only at the registered empty flag, keeping the
  // synchronised write pointer off the accept path.
  always_comb begin
    bin_wr_ptr       = '0;
    bin_wr_ptr[ADDR] = sync_wr_ptr[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) begin
      bin_wr_ptr[i] = bin_wr_ptr[i+1] ^ sync_wr_ptr[i];
    end

    acc      = rd_en & ~empty_q;
    rd_ptr_d = rd_ptr_q + {{ADDR{1'b0}}, acc};
    gray_d   = rd_ptr_d ^ (rd_ptr_d >> 1);
    level_d  = bin_wr_ptr - rd_ptr_d;
    empty_d  = (rd_ptr_d == bin_wr_ptr);
    aempty_d = (level_d <= AeThresh);
    uf_d     = rd_en & empty_q;
    sticky_d = sticky_q;
    if (uf_d) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      uf_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      uf_q     <= uf_d;
      sticky_q <= sticky_d;
    end
  end

  assign rd_add            = rd_ptr_q[ADDR-1:0];
  assign gr_rd_ptr         = gray_q;
  assign empty_flag        = empty_q;
  assign almost_empty_flag = aempty_q;
  assign rd_level          = level_q;
  assign underflow         = uf_q;
  assign underflow_sticky  = sticky_q;

endmodule

// File: tb/tb_empty_flag_calc.sv
// Self-checking bench for empty_flag_calc: directed scenarios then random traffic,
// compared against a word-counting model of the FIFO read side.
module tb_empty_flag_calc;

  localparam int ADDR  = 4;
  localparam int DEPTH = 1 << ADDR;
  localparam int AE    = 2;

  logic            rd_clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_en = 1'b0;
  logic            clr_err = 1'b0;
  logic [ADDR:0]   sync_wr_ptr = '0;
  logic [ADDR-1:0] rd_add;
  logic [ADDR:0]   gr_rd_ptr;
  logic            empty_flag;
  logic            almost_empty_flag;
  logic [ADDR:0]   rd_level;
  logic            underflow;
  logic            underflow_sticky;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: total words written (as visible to the reader) and read.
  int wrTotal = 0;
  int mRd     = 0;
  int mLevel  = 0;
  bit mEmpty  = 1;
  bit mAe     = 1;
  bit mUf     = 0;
  bit mSticky = 0;

  empty_flag_calc #(.ADDR(ADDR), .AE_THRESH(AE)) dut (
    .rd_clk            (rd_clk),
    .rst               (rst),
    .rd_en             (rd_en),
    .clr_err           (clr_err),
    .sync_wr_ptr       (sync_wr_ptr),
    .rd_add            (rd_add),
    .gr_rd_ptr         (gr_rd_ptr),
    .empty_flag        (empty_flag),
    .almost_empty_flag (almost_empty_flag),
    .rd_level          (rd_level),
    .underflow         (underflow),
    .underflow_sticky  (underflow_sticky)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic int toGray(input int n);
    int b;
    b = n % (2 * DEPTH);
    return b ^ (b >> 1);
  endfunction

  task automatic checkEq(input string tag, input int obs, input int exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkEq("rd_add", int'(rd_add), mRd % DEPTH);
    checkEq("gr_rd_ptr", int'(gr_rd_ptr), toGray(mRd));
    checkEq("empty_flag", int'(empty_flag), int'(mEmpty));
    checkEq("almost_empty_flag", int'(almost_empty_flag), int'(mAe));
    checkEq("rd_level", int'(rd_level), mLevel);
    checkEq("underflow", int'(underflow), int'(mUf));
    checkEq("underflow_sticky", int'(underflow_sticky), int'(mSticky));
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, check #1 later.
  task automatic applyStimulus(input bit r, input bit e, input bit c);
    bit ufNow;
    rst         = r;
    rd_en       = e;
    clr_err     = c;
    sync_wr_ptr = (ADDR+1)'(toGray(wrTotal));
    @(posedge rd_clk);
    if (r) begin
      mRd = 0; mLevel = 0; mEmpty = 1; mAe = 1; mUf = 0; mSticky = 0;
    end else begin
      ufNow = e && mEmpty;
      if (e && !mEmpty) mRd++;
      mLevel = wrTotal - mRd;
      mEmpty = (mLevel == 0);
      mAe    = (mLevel <= AE);
      mUf    = ufNow;
      if (ufNow) mSticky = 1;
      else if (c) mSticky = 0;
    end
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int cycles, input bit e);
    wrTotal = 0;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, e, 1'b0);
  endtask

  initial begin
    // Reset held with a pending read.
    doReset(2, 1'b1);
    checkEq("reset_gr", int'(gr_rd_ptr), 0);
    checkEq("reset_empty", int'(empty_flag), 1);

    // Three words appear, then drained back to back.
    wrTotal = 3;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkEq("fill3_level", int'(rd_level), 3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkEq("drain_gr", int'(gr_rd_ptr), 5'b00010);
    checkEq("drain_empty", int'(empty_flag), 1);

    // Full FIFO read through the wrap.
    doReset(1, 1'b0);
    wrTotal = 16;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkEq("full_level", int'(rd_level), 16);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkEq("wrap_gr", int'(gr_rd_ptr), 5'b11000);
    checkEq("wrap_add", int'(rd_add), 0);

    // Underflow for two cycles, then clear the sticky bit.
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkEq("uf_sticky", int'(underflow_sticky), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkEq("uf_cleared", int'(underflow_sticky), 0);

    // Write and read in the same cycle at level 5.
    wrTotal += 5;
    applyStimulus(1'b0, 1'b0, 1'b0);
    wrTotal += 1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkEq("simul_level", int'(rd_level), 5);

    // Reset in the middle of traffic with level 7, address 9.
    doReset(1, 1'b0);
    wrTotal = 16;
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkEq("mid_level", int'(rd_level), 7);
    doReset(1, 1'b1);
    checkEq("mid_rst_add", int'(rd_add), 0);
    wrTotal = 4;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Random traffic with occasional resets and clears.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        doReset(1, 1'($urandom_range(1)));
      end else begin
        if ((wrTotal - mRd) < DEPTH && $urandom_range(1) == 1) wrTotal++;
        applyStimulus(1'b0, $urandom_range(9) < 6, $urandom_range(9) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
